// File: rtl/alu_pkg.sv
// Shared definitions for the ALU execution stage: operation codes and FSM state encoding.
package alu_pkg;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SLL  = 3'b001;
    localparam logic [2:0] ALU_XOR  = 3'b010;
    localparam logic [2:0] ALU_AND  = 3'b011;
    localparam logic [2:0] ALU_MUL  = 3'b100;
    localparam logic [2:0] ALU_SUB  = 3'b101;
    localparam logic [2:0] ALU_ADDI = 3'b110;
    localparam logic [2:0] ALU_SRAI = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } alu_state_e;

endpackage

// File: rtl/alu_exec_mul_iter.sv
// Iterative shift-add multiplier: one multiplier bit per cycle, LSB first, low WIDTH bits kept.
module mul_iter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             run,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             done_c,
    output logic [WIDTH-1:0] product_c
);

    localparam int unsigned CNT_W = $clog2(WIDTH);

    logic [WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0] mplier_q;
    logic [WIDTH-1:0] acc_q;
    logic [CNT_W-1:0] cnt_q;

    // Partial product after this cycle's iteration; final result when done_c is high.
    assign product_c = acc_q + (mplier_q[0] ? mcand_q : '0);
    assign done_c    = run && (cnt_q == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else if (start) begin
            mcand_q  <= op_a;
            mplier_q <= op_b;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else if (run) begin
            acc_q    <= product_c;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/alu_exec.sv
// Registered ALU execution stage with valid/ready handshake and iterative multiply.
// Define ALU_FAST_MUL_EN to compute MUL combinationally in a single cycle instead.
module alu_exec
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [2:0]       ALUfunc_i,
    input  logic [WIDTH-1:0] data1_i,
    input  logic [WIDTH-1:0] data2_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [WIDTH-1:0] data_o,
    output logic             zero_o,
    output logic             busy_o
);

    localparam int unsigned SHW = $clog2(WIDTH);

    alu_state_e       state_q;
    alu_state_e       state_d;
    logic             accept_c;
    logic [SHW-1:0]   shamt_c;
    logic [WIDTH-1:0] alu_res_c;
    logic [WIDTH-1:0] data_d;
    logic             valid_d;
    logic             zero_d;

`ifndef ALU_FAST_MUL_EN
    logic             mul_start_c;
    logic             mul_run_c;
    logic             mul_done_c;
    logic [WIDTH-1:0] mul_product_c;
`endif

    assign ready_o  = (state_q == IDLE) || ((state_q == DONE) && ready_i);
    assign accept_c = valid_i && ready_o;
    assign shamt_c  = data2_i[SHW-1:0];

    // Single-cycle datapath; MUL only contributes here in the fast build.
    always_comb begin
        alu_res_c = '0;
        case (ALUfunc_i)
            ALU_ADD,
            ALU_ADDI: alu_res_c = data1_i + data2_i;
            ALU_SLL:  alu_res_c = data1_i << shamt_c;
            ALU_XOR:  alu_res_c = data1_i ^ data2_i;
            ALU_AND:  alu_res_c = data1_i & data2_i;
            ALU_SUB:  alu_res_c = data1_i - data2_i;
            ALU_SRAI: alu_res_c = $unsigned($signed(data1_i) >>> shamt_c);
`ifdef ALU_FAST_MUL_EN
            ALU_MUL:  alu_res_c = data1_i * data2_i;
`endif
            default:  alu_res_c = '0;
        endcase
    end

    // Next-state and registered-output values.
    always_comb begin
        state_d = state_q;
        data_d  = data_o;
        zero_d  = zero_o;
        valid_d = valid_o;
`ifndef ALU_FAST_MUL_EN
        mul_start_c = 1'b0;
`endif
        case (state_q)
            IDLE, DONE: begin
                if (accept_c) begin
`ifndef ALU_FAST_MUL_EN
                    if (ALUfunc_i == ALU_MUL) begin
                        state_d     = MUL;
                        valid_d     = 1'b0;
                        mul_start_c = 1'b1;
                    end else
`endif
                    begin
                        state_d = DONE;
                        data_d  = alu_res_c;
                        zero_d  = (alu_res_c == '0);
                        valid_d = 1'b1;
                    end
                end else if ((state_q == DONE) && ready_i) begin
                    state_d = IDLE;
                    valid_d = 1'b0;
                end
            end
`ifndef ALU_FAST_MUL_EN
            MUL: begin
                if (mul_done_c) begin
                    state_d = DONE;
                    data_d  = mul_product_c;
                    zero_d  = (mul_product_c == '0);
                    valid_d = 1'b1;
                end
            end
`endif
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            valid_o <= 1'b0;
            data_o  <= '0;
            zero_o  <= 1'b0;
        end else begin
            state_q <= state_d;
            valid_o <= valid_d;
            data_o  <= data_d;
            zero_o  <= zero_d;
        end
    end

`ifndef ALU_FAST_MUL_EN
    assign mul_run_c = (state_q == MUL);

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            busy_o <= 1'b0;
        end else begin
            busy_o <= (state_d == MUL);
        end
    end

    mul_iter #(
        .WIDTH (WIDTH)
    ) u_mul_iter (
        .clk       (clk_i),
        .rst_n     (rst_n_i),
        .start     (mul_start_c),
        .run       (mul_run_c),
        .op_a      (data1_i),
        .op_b      (data2_i),
        .done_c    (mul_done_c),
        .product_c (mul_product_c)
    );
`else
    assign busy_o = 1'b0;
`endif

endmodule

// File: tb/tb_alu_exec.sv
// Directed self-checking bench for alu_exec (WIDTH=32), both MUL build variants.
module tb_alu_exec;
    import alu_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        valid_i;
    logic        ready_o;
    logic [2:0]  func;
    logic [31:0] d1;
    logic [31:0] d2;
    logic        valid_o;
    logic        ready_i;
    logic [31:0] data_o;
    logic        zero_o;
    logic        busy_o;

    int total = 0;
    int bad   = 0;
    logic flag;

    alu_exec #(.WIDTH(32)) dut (
        .clk_i     (clk),
        .rst_n_i   (rst_n),
        .valid_i   (valid_i),
        .ready_o   (ready_o),
        .ALUfunc_i (func),
        .data1_i   (d1),
        .data2_i   (d2),
        .valid_o   (valid_o),
        .ready_i   (ready_i),
        .data_o    (data_o),
        .zero_o    (zero_o),
        .busy_o    (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Advance one edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic v, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        valid_i = v;
        func    = op;
        d1      = a;
        d2      = b;
    endtask

    initial begin
        rst_n   = 1'b0;
        ready_i = 1'b1;
        offer(1'b0, ALU_ADD, 32'd0, 32'd0);
        step();
        step();
        chk("rst_valid", 32'(valid_o), 32'd0);
        chk("rst_ready", 32'(ready_o), 32'd1);
        chk("rst_data",  data_o,       32'd0);
        chk("rst_busy",  32'(busy_o),  32'd0);
        chk("rst_zero",  32'(zero_o),  32'd0);
        rst_n = 1'b1;

        // Back-to-back single-cycle ops with ready_i held high.
        offer(1'b1, ALU_ADD, 32'd5, 32'd7);
        step();
        chk("add_valid", 32'(valid_o), 32'd1);
        chk("add_data",  data_o,       32'd12);
        chk("add_zero",  32'(zero_o),  32'd0);
        chk("add_ready", 32'(ready_o), 32'd1);
        offer(1'b1, ALU_SUB, 32'd5, 32'd7);
        step();
        chk("sub_valid", 32'(valid_o), 32'd1);
        chk("sub_data",  data_o,       32'hFFFF_FFFE);
        chk("sub_zero",  32'(zero_o),  32'd0);
        offer(1'b1, ALU_SRAI, 32'h8000_0000, 32'd4);
        step();
        chk("srai_data", data_o, 32'hF800_0000);
        offer(1'b1, ALU_SLL, 32'd1, 32'd31);
        step();
        chk("sll_data", data_o, 32'h8000_0000);
        offer(1'b1, ALU_XOR, 32'h1234_5678, 32'h1234_5678);
        step();
        chk("xor_data", data_o,      32'd0);
        chk("xor_zero", 32'(zero_o), 32'd1);
        offer(1'b1, ALU_ADDI, 32'hFFFF_FFFF, 32'd1);
        step();
        chk("addi_wrap", data_o,      32'd0);
        chk("addi_zero", 32'(zero_o), 32'd1);
        offer(1'b1, ALU_SRAI, 32'h4000_0000, 32'd33);
        step();
        chk("srai_shamt5", data_o,      32'h2000_0000);
        chk("srai_nzero",  32'(zero_o), 32'd0);
        offer(1'b0, ALU_ADD, 32'd0, 32'd0);
        step();
        chk("drain_valid", 32'(valid_o), 32'd0);

        // Multiply; operands are scrambled after acceptance to prove latching.
        offer(1'b1, ALU_MUL, 32'hFFFF_FFFF, 32'd3);
        step();
`ifdef ALU_FAST_MUL_EN
        offer(1'b0, ALU_ADD, 32'h5555_5555, 32'h1111_1111);
        chk("fmul_valid", 32'(valid_o), 32'd1);
        chk("fmul_data",  data_o,       32'hFFFF_FFFD);
        chk("fmul_busy",  32'(busy_o),  32'd0);
`else
        // Iterations at E1..E32: valid_o must stay low through E31 and rise at E32.
        chk("mul_ready0", 32'(ready_o), 32'd0);
        chk("mul_busy0",  32'(busy_o),  32'd1);
        offer(1'b1, ALU_ADD, 32'h5555_5555, 32'h1111_1111);
        flag = 1'b0;
        for (int i = 1; i <= 31; i++) begin
            step();
            if (valid_o || ready_o || !busy_o) flag = 1'b1;
        end
        chk("mul_stall", 32'(flag), 32'd0);
        offer(1'b0, ALU_ADD, 32'd0, 32'd0);
        step();
        chk("mul_valid", 32'(valid_o), 32'd1);
        chk("mul_data",  data_o,       32'hFFFF_FFFD);
        chk("mul_busy",  32'(busy_o),  32'd0);
        chk("mul_zero",  32'(zero_o),  32'd0);
`endif
        offer(1'b0, ALU_ADD, 32'd0, 32'd0);
        step();
        chk("mul_drain", 32'(valid_o), 32'd0);

        // Backpressure: result must hold and new offers must be refused.
        ready_i = 1'b0;
        offer(1'b1, ALU_AND, 32'h0000_F0F0, 32'h0000_FF00);
        step();
        offer(1'b1, ALU_XOR, 32'd1, 32'd2);
        flag = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (data_o !== 32'h0000_F000 || ready_o || !valid_o) flag = 1'b1;
            step();
        end
        chk("bp_hold",  32'(flag),    32'd0);
        chk("bp_data",  data_o,       32'h0000_F000);
        chk("bp_ready", 32'(ready_o), 32'd0);
        ready_i = 1'b1;
        offer(1'b0, ALU_ADD, 32'd0, 32'd0);
        step();
        chk("bp_consume", 32'(valid_o), 32'd0);
        chk("bp_keep",    data_o,       32'h0000_F000);

        // Reset in the middle of a multiply aborts it.
        offer(1'b1, ALU_MUL, 32'd7, 32'd9);
        step();
        offer(1'b0, ALU_ADD, 32'd0, 32'd0);
        for (int i = 0; i < 10; i++) step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("abort_valid", 32'(valid_o), 32'd0);
        chk("abort_ready", 32'(ready_o), 32'd1);
        chk("abort_busy",  32'(busy_o),  32'd0);
        chk("abort_data",  data_o,       32'd0);
        step();
        chk("abort_quiet", 32'(valid_o), 32'd0);
        offer(1'b1, ALU_ADD, 32'd1, 32'd1);
        step();
        chk("post_valid", 32'(valid_o), 32'd1);
        chk("post_data",  data_o,       32'd2);
        offer(1'b0, ALU_ADD, 32'd0, 32'd0);
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
